// File: rtl/vip_window_scan_ctrl.sv
// vip_window_scan_ctrl
// Frame-scan controller behind the 3x3 window generator. It tracks the column and row
// of each window-generator output pixel, and it qualifies only fully populated windows.
// It reports the window-centre coordinate and flags malformed lines and frames.
module vip_window_scan_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mat_vsync,
    input  logic             mat_href,
    input  logic             mat_clken,
    output logic             win_valid,
    output logic [CNT_W-1:0] ctr_x,
    output logic [CNT_W-1:0] ctr_y,
    output logic             frame_done,
    output logic             line_len_err,
    output logic             frm_len_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_W        = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] LP_LAST_ROW = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_TWO      = CNT_W'(2);

    state_t           r_state;
    logic             r_vsync_d;
    logic             r_href_d;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic             r_win_valid;
    logic [CNT_W-1:0] r_ctr_x;
    logic [CNT_W-1:0] r_ctr_y;
    logic             r_frame_done;
    logic             r_line_len_err;
    logic             r_frm_len_err;
    logic             r_busy;

    logic w_vs_rise;
    logic w_href_rise;
    logic w_href_fall;
    logic w_pix;
    logic w_in_frame;

    assign w_vs_rise   = mat_vsync & ~r_vsync_d;
    assign w_href_rise = mat_href & ~r_href_d;
    assign w_href_fall = ~mat_href & r_href_d;
    assign w_pix       = mat_href & mat_clken;
    assign w_in_frame  = (r_state == S_FILL) || (r_state == S_ACTIVE);

    // Scan FSM: edge history, column/row counters, window qualification and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_vsync_d      <= 1'b0;
            r_href_d       <= 1'b0;
            r_col          <= '0;
            r_row          <= '0;
            r_win_valid    <= 1'b0;
            r_ctr_x        <= '0;
            r_ctr_y        <= '0;
            r_frame_done   <= 1'b0;
            r_line_len_err <= 1'b0;
            r_frm_len_err  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_vsync_d    <= mat_vsync;
            r_href_d     <= mat_href;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_vs_rise) begin
                // A restart overrides any line ending on the same edge, but a set condition
                // still beats the clear on both sticky flags.
                r_frm_len_err  <= w_in_frame | ((r_state == S_DONE) & w_href_rise);
                r_line_len_err <= w_in_frame & w_href_fall & (r_col != LP_W);
                r_col          <= '0;
                r_row          <= '0;
                r_state        <= S_FILL;
                r_busy         <= 1'b1;
            end else begin
                case (r_state)
                    S_FILL, S_ACTIVE: begin
                        if (w_pix) begin
                            if (r_col != LP_W) begin
                                r_col <= r_col + LP_ONE;
                            end
                            if ((r_state == S_ACTIVE) && (r_col >= LP_TWO) && (r_col < LP_W)) begin
                                r_win_valid <= 1'b1;
                                r_ctr_x     <= r_col - LP_ONE;
                                r_ctr_y     <= r_row - LP_ONE;
                            end
                        end
                        if (w_href_fall) begin
                            r_col <= '0;
                            r_row <= r_row + LP_ONE;
                            if (r_col != LP_W) begin
                                r_line_len_err <= 1'b1;
                            end
                            if ((r_state == S_FILL) && (r_row == LP_ONE)) begin
                                r_state <= S_ACTIVE;
                            end else if ((r_state == S_ACTIVE) && (r_row == LP_LAST_ROW)) begin
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                                r_busy       <= 1'b0;
                            end
                        end
                    end
                    S_DONE: begin
                        if (w_href_rise) begin
                            r_frm_len_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign win_valid    = r_win_valid;
    assign ctr_x        = r_ctr_x;
    assign ctr_y        = r_ctr_y;
    assign frame_done   = r_frame_done;
    assign line_len_err = r_line_len_err;
    assign frm_len_err  = r_frm_len_err;
    assign busy         = r_busy;

endmodule
